gb_mbc_ctrl: RTL and testbench

GB_MBC_CTRL -- requirements
Module: gb_mbc_ctrl

---
 rtl/gb_cart_pkg.sv | 22 ++
 rtl/gb_sync.sv | 27 ++
 rtl/gb_mbc_ctrl.sv | 116 +++++++++++
 tb/tb_gb_mbc_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/gb_cart_pkg.sv
// Shared constants and FSM state type for the GB cartridge MBC controller.
// Region bases split the 0x0000-0x7FFF write window into the four MBC registers.
package gb_cart_pkg;

  localparam int ROM_ADDR_W = 21;

  localparam logic [15:0] RAM_EN_BASE  = 16'h0000;
  localparam logic [15:0] BANK_LO_BASE = 16'h2000;
  localparam logic [15:0] BANK_HI_BASE = 16'h4000;
  localparam logic [15:0] MODE_BASE    = 16'h6000;
  localparam logic [15:0] REGION_END   = 16'h8000;

  localparam logic [3:0] RAM_EN_KEY = 4'hA;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WR_LOW    = 2'd1,
    WR_COMMIT = 2'd2,
    RD_ACT    = 2'd3
  } mbc_state_e;

endpackage

// File: rtl/gb_sync.sv
// Multi-flop synchronizer for an active-low GB bus strobe; resets to the
// inactive (high) level so no phantom strobe appears after reset.
module gb_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '1;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        chain[i] <= chain[i-1];
      end
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/gb_mbc_ctrl.sv
// MBC-style GB cartridge controller: decodes bus writes into bank registers and
// maps ROM addresses. Define GB_MBC_RAM_BANK_EN to drive ram_bank from bank_hi.
module gb_mbc_ctrl
  import gb_cart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           gb_addr,
  input  logic [7:0]            gb_din,
  input  logic                  gb_wr_n,
  input  logic                  gb_rd_n,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  output logic                  data_oe,
  output logic                  ram_en,
  output logic [1:0]            ram_bank,
  output logic                  bank_mode
);

  // Strobe semantics: a write is accepted only when the synchronized wr_n stays
  // low for at least 2 clk and then rises; the latched bus values commit for
  // one clk. A read drives data_oe while rd_n is low in the ROM window; a
  // concurrent write always takes priority over a read.
  mbc_state_e state, state_next;
  logic        wr_n_s, rd_n_s;
  logic [1:0]  low_cnt;
  logic [15:0] lat_addr;
  logic [4:0]  lat_data;
  logic [4:0]  bank_lo;
  logic [1:0]  bank_hi;
  logic        latch_en, commit, oe_next;
  logic        unused_din;

  assign unused_din = ^gb_din[7:5];

  gb_sync #(.STAGES(SYNC_STAGES)) u_sync_wr (.clk(clk), .rst(rst), .d(gb_wr_n), .q(wr_n_s));
  gb_sync #(.STAGES(SYNC_STAGES)) u_sync_rd (.clk(clk), .rst(rst), .d(gb_rd_n), .q(rd_n_s));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!wr_n_s)                      state_next = WR_LOW;
        else if (!rd_n_s && !gb_addr[15]) state_next = RD_ACT;
      end
      WR_LOW: begin
        if (wr_n_s) state_next = (low_cnt == 2'd2) ? WR_COMMIT : IDLE;
      end
      WR_COMMIT: state_next = IDLE;
      RD_ACT: begin
        if (!wr_n_s)                    state_next = WR_LOW;
        else if (rd_n_s || gb_addr[15]) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    latch_en = (state == WR_LOW);
    commit   = (state == WR_COMMIT);
    oe_next  = (state_next == RD_ACT);
  end

  // low_cnt counts synchronized-low clocks, saturating at 2; the IDLE sample
  // that triggered the entry into WR_LOW is the first one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      low_cnt  <= 2'd0;
      lat_addr <= 16'h0000;
      lat_data <= 5'd0;
    end else begin
      if (state_next == WR_LOW && state != WR_LOW) low_cnt <= 2'd1;
      else if (latch_en && !wr_n_s && low_cnt != 2'd2) low_cnt <= low_cnt + 2'd1;
      if (latch_en) begin
        lat_addr <= gb_addr;
        lat_data <= gb_din[4:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_lo   <= 5'd1;
      bank_hi   <= 2'd0;
      bank_mode <= 1'b0;
      ram_en    <= 1'b0;
      data_oe   <= 1'b0;
    end else begin
      data_oe <= oe_next;
      if (commit && lat_addr < REGION_END) begin
        if (lat_addr < BANK_LO_BASE)      ram_en    <= (lat_data[3:0] == RAM_EN_KEY);
        else if (lat_addr < BANK_HI_BASE) bank_lo   <= (lat_data == 5'd0) ? 5'd1 : lat_data;
        else if (lat_addr < MODE_BASE)    bank_hi   <= lat_data[1:0];
        else                              bank_mode <= lat_data[0];
      end
    end
  end

  always_comb begin
    if (gb_addr[14]) rom_addr = {bank_hi, bank_lo, gb_addr[13:0]};
    else             rom_addr = {(bank_mode ? bank_hi : 2'b00), 5'b00000, gb_addr[13:0]};
  end

`ifdef GB_MBC_RAM_BANK_EN
  assign ram_bank = bank_mode ? bank_hi : 2'b00;
`else
  assign ram_bank = 2'b00;
`endif

endmodule

// File: tb/tb_gb_mbc_ctrl.sv
// Directed bench for gb_mbc_ctrl: a register-level model of the MBC is compared
// against the DUT every cycle while quiet, plus hand-computed literal checks.
module tb_gb_mbc_ctrl;

  localparam int SYNC_STAGES = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] gb_addr;
  logic [7:0]  gb_din;
  logic        gb_wr_n, gb_rd_n;
  logic [20:0] rom_addr;
  logic        data_oe, ram_en, bank_mode;
  logic [1:0]  ram_bank;

  int n_vec = 0;
  int n_err = 0;

  // model state
  int  m_lo, m_hi, m_mode, m_ram_en, m_oe;
  bit  model_valid = 1'b0;

  always #5 clk = ~clk;

  gb_mbc_ctrl #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst(rst), .gb_addr(gb_addr), .gb_din(gb_din),
    .gb_wr_n(gb_wr_n), .gb_rd_n(gb_rd_n), .rom_addr(rom_addr),
    .data_oe(data_oe), .ram_en(ram_en), .ram_bank(ram_bank), .bank_mode(bank_mode)
  );

  function automatic int model_rom(input int a);
    int bank;
    if ((a / 16384) % 2 == 1) bank = m_hi * 32 + m_lo;
    else                      bank = (m_mode != 0) ? m_hi * 32 : 0;
    return bank * 16384 + (a % 16384);
  endfunction

  function automatic int model_ram_bank();
`ifdef GB_MBC_RAM_BANK_EN
    return (m_mode != 0) ? m_hi : 0;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_lo = 1; m_hi = 0; m_mode = 0; m_ram_en = 0; m_oe = 0;
  endtask

  task automatic model_write(input int a, input int d);
    if (a < 'h2000)      m_ram_en = ((d % 16) == 10) ? 1 : 0;
    else if (a < 'h4000) m_lo = ((d % 32) == 0) ? 1 : d % 32;
    else if (a < 'h6000) m_hi = d % 4;
    else if (a < 'h8000) m_mode = d % 2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && model_valid) begin
      check("model_rom_addr", 32'(rom_addr), model_rom(int'(gb_addr)));
      check("model_ram_en", 32'(ram_en), m_ram_en);
      check("model_bank_mode", 32'(bank_mode), m_mode);
      check("model_ram_bank", 32'(ram_bank), model_ram_bank());
      check("model_data_oe", 32'(data_oe), m_oe);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int low_cycles, input bit apply);
    model_valid = 1'b0;
    gb_addr = a; gb_din = d; gb_wr_n = 1'b0;
    tick(low_cycles);
    gb_wr_n = 1'b1;
    tick(SYNC_STAGES + 4);
    if (apply) model_write(int'(a), int'(d));
    model_valid = 1'b1;
    tick(2);
  endtask

  task automatic do_read(input logic [15:0] a, input logic [20:0] lit_rom);
    bit got;
    model_valid = 1'b0;
    gb_addr = a; gb_rd_n = 1'b0;
    got = 1'b0;
    for (int i = 0; i < SYNC_STAGES + 1; i++) begin
      @(posedge clk); #1;
      if (data_oe) begin got = 1'b1; break; end
    end
    check("oe_latency", 32'(got), 32'd1);
    m_oe = 1; model_valid = 1'b1;
    tick(2);
    check("rom_literal", 32'(rom_addr), 32'(lit_rom));
    gb_rd_n = 1'b1; model_valid = 1'b0;
    tick(SYNC_STAGES + 2);
    m_oe = 0; model_valid = 1'b1;
    tick(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; gb_addr = 16'h0000; gb_din = 8'h00; gb_wr_n = 1'b1; gb_rd_n = 1'b1;
    model_reset();
    tick(3);
    check("rst_rom_addr", 32'(rom_addr), 32'h000000);
    check("rst_data_oe", 32'(data_oe), 32'd0);
    check("rst_ram_en", 32'(ram_en), 32'd0);
    check("rst_ram_bank", 32'(ram_bank), 32'd0);
    check("rst_bank_mode", 32'(bank_mode), 32'd0);
    gb_addr = 16'h4000; #1;
    check("rst_bank_lo", 32'(rom_addr), 32'h004000);
    rst = 1'b0;
    tick(2);
    model_valid = 1'b1;

    do_read(16'h4123, 21'h004123);

    do_write(16'h2000, 8'h00, 4, 1'b1);
    do_read(16'h4000, 21'h004000);
    do_write(16'h2100, 8'h13, 4, 1'b1);
    do_read(16'h7FFF, 21'h04FFFF);

    do_write(16'h4000, 8'h02, 4, 1'b1);
    do_write(16'h6000, 8'h01, 4, 1'b1);
    do_read(16'h0010, 21'h100010);
`ifdef GB_MBC_RAM_BANK_EN
    check("ram_bank_lit", 32'(ram_bank), 32'd2);
`else
    check("ram_bank_lit", 32'(ram_bank), 32'd0);
`endif
    do_read(16'h4000, 21'h14C000);

    do_write(16'h0000, 8'h0A, 4, 1'b1);
    check("ram_en_0a", 32'(ram_en), 32'd1);
    do_write(16'h0000, 8'h1A, 4, 1'b1);
    check("ram_en_1a", 32'(ram_en), 32'd1);
    do_write(16'h0000, 8'h0B, 4, 1'b1);
    check("ram_en_0b", 32'(ram_en), 32'd0);
    do_write(16'hA000, 8'h55, 4, 1'b1);
    do_read(16'h7FFF, 21'h14FFFF);

    // read outside the ROM window must never drive the bus
    gb_addr = 16'hA000; gb_rd_n = 1'b0;
    tick(6);
    gb_rd_n = 1'b1;
    tick(4);

    do_write(16'h6000, 8'h00, 4, 1'b1);
    do_read(16'h0010, 21'h000010);

    do_write(16'h2000, 8'h05, 1, 1'b0);
    do_read(16'h4000, 21'h14C000);

    model_valid = 1'b0;
    gb_addr = 16'h2000; gb_din = 8'h07; gb_wr_n = 1'b0; gb_rd_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("oe_write_wins", 32'(data_oe), 32'd0);
    end
    @(posedge clk); #1;
    gb_wr_n = 1'b1; gb_rd_n = 1'b1;
    tick(SYNC_STAGES + 4);
    model_write('h2000, 'h07);
    model_valid = 1'b1;
    tick(2);
    do_read(16'h4000, 21'h11C000);

    do_write(16'h0000, 8'h0A, 4, 1'b1);
    do_write(16'h6000, 8'h01, 4, 1'b1);
    check("pre_rst_ram_en", 32'(ram_en), 32'd1);

    model_valid = 1'b0;
    gb_addr = 16'h4000; gb_din = 8'h03; gb_wr_n = 1'b0;
    tick(4);
    #2 rst = 1'b1;
    #1;
    check("wrlow_rst_rom_addr", 32'(rom_addr), 32'h004000);
    check("wrlow_rst_data_oe", 32'(data_oe), 32'd0);
    check("wrlow_rst_ram_en", 32'(ram_en), 32'd0);
    check("wrlow_rst_ram_bank", 32'(ram_bank), 32'd0);
    check("wrlow_rst_bank_mode", 32'(bank_mode), 32'd0);
    gb_wr_n = 1'b1;
    tick(2);
    rst = 1'b0;
    model_reset();
    tick(SYNC_STAGES + 4);
    model_valid = 1'b1;
    do_read(16'h4000, 21'h004000);
    do_read(16'h7FFF, 21'h007FFF);

    model_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
